// File: rtl/fifo_acq_pkg.sv
// Shared types and default sizes for the sensor -> FIFO -> DAQ acquisition sequencer.
package fifo_acq_pkg;

    localparam int WIDTH_DEF = 10;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        CAPTURE = 3'd2,
        DRAIN   = 3'd3,
        FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/fifo_acq_ctrl_if.sv
// FIFO-side and DAQ-stream signals of the acquisition sequencer, grouped as one bus.
interface fifo_acq_ctrl_if import fifo_acq_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             FifoFlush;
    logic             FifoWrEnable;
    logic [WIDTH-1:0] FifoWrData;
    logic             FifoFull;
    logic             FifoEmpty;
    logic             FifoRdEnable;
    logic [WIDTH-1:0] FifoRdData;
    logic [WIDTH-1:0] TxData;
    logic             TxValid;
    logic             TxReady;

    // Tx stream: a word moves on a cycle with TxValid & TxReady; once raised, TxValid
    // and TxData hold unchanged until that cycle, and TxValid never waits on TxReady.
    modport master (
        output FifoFlush, FifoWrEnable, FifoWrData, FifoRdEnable, TxData, TxValid,
        input  FifoFull, FifoEmpty, FifoRdData, TxReady
    );

    modport slave (
        input  FifoFlush, FifoWrEnable, FifoWrData, FifoRdEnable, TxData, TxValid,
        output FifoFull, FifoEmpty, FifoRdData, TxReady
    );
endinterface

// File: rtl/fifo_rd_stage.sv
// Drain engine: issues single outstanding FIFO reads and holds the result in the Tx register.
module fifo_rd_stage import fifo_acq_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             active,
    input  logic             clear,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             tx_ready,
    output logic             rd_en,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    output logic             rd_pending
);

    // Read only when the Tx register is free or being emptied this cycle.
    assign rd_en = active & ~fifo_empty & ~rd_pending & (~tx_valid | tx_ready);

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            rd_pending <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
        end else if (clear) begin
            rd_pending <= 1'b0;
            tx_valid   <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            if (rd_pending) begin
                tx_data  <= rd_data;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_acq_ctrl.sv
// Acquisition sequencer: flushes the FIFO, gates NumSamples ADC samples in, drains them to the DAQ.
module fifo_acq_ctrl import fifo_acq_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [CNT_W-1:0] NumSamples,
    input  logic [WIDTH-1:0] AdcData,
    input  logic             AdcValid,
    fifo_acq_ctrl_if.master  bus,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow,
    output state_t           dbg_state
);

    state_t           state, next_state;
    logic [CNT_W-1:0] n_q, cnt_q;
    logic             ovf_q, flush_q;
    logic             rd_pending;
    logic             cap_last, drained;
    logic             wr_en, drain_active, drain_clear;

    // cnt counts the sample window, so dropped samples advance it too.
    assign cap_last = AdcValid && (cnt_q == n_q - CNT_W'(1));
    assign drained  = bus.FifoEmpty && !rd_pending && !bus.TxValid;

    always_ff @(posedge clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = FLUSH;
            FLUSH:   next_state = (n_q != '0) ? CAPTURE : FINISH;
            CAPTURE: if (cap_last) next_state = DRAIN;
            DRAIN:   if (drained) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Busy         = 1'b0;
        Done         = 1'b0;
        wr_en        = 1'b0;
        drain_active = 1'b0;
        drain_clear  = 1'b0;
        case (state)
            FLUSH: begin
                Busy        = 1'b1;
                drain_clear = 1'b1;
            end
            CAPTURE: begin
                Busy         = 1'b1;
                wr_en        = AdcValid & ~bus.FifoFull;
                drain_active = 1'b1;
            end
            DRAIN: begin
                Busy         = 1'b1;
                drain_active = 1'b1;
            end
            FINISH:  Done = 1'b1;
            default: ;
        endcase
    end

    // FifoFlush is registered so the FIFO sees a glitch-free clear, high through reset.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            n_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            flush_q <= 1'b1;
        end else begin
            flush_q <= (next_state == FLUSH);
            if (state == IDLE && Start) begin
                n_q   <= NumSamples;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (state == CAPTURE && AdcValid) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (bus.FifoFull) ovf_q <= 1'b1;
            end
        end
    end

    assign bus.FifoFlush    = flush_q;
    assign bus.FifoWrEnable = wr_en;
    assign bus.FifoWrData   = AdcData;
    assign Overflow         = ovf_q;
    assign dbg_state        = state;

    fifo_rd_stage #(.WIDTH(WIDTH)) u_rd_stage (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .active     (drain_active),
        .clear      (drain_clear),
        .fifo_empty (bus.FifoEmpty),
        .rd_data    (bus.FifoRdData),
        .tx_ready   (bus.TxReady),
        .rd_en      (bus.FifoRdEnable),
        .tx_data    (bus.TxData),
        .tx_valid   (bus.TxValid),
        .rd_pending (rd_pending)
    );

endmodule
